// File: rtl/cpu_pkg.sv
// Shared CPU types: writeback payload widths and the entry carried from
// execution-unit producers through the writeback arbiter.
package cpu_pkg;
    localparam int VREG_W = 5;
    localparam int REG_W  = 5;
    localparam int XLEN   = 32;

    typedef struct packed {
        logic [VREG_W-1:0] vregid;
        logic [REG_W-1:0]  dest;
        logic [XLEN-1:0]   val;
    } wb_entry_t;
endpackage

// File: rtl/wb_src_fifo.sv
// Per-producer result FIFO. Ready depends only on the stored count, so a full
// FIFO stays not-ready in the cycle it is popped.
module wb_src_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  wb_entry_t             push_data,
    input  logic                  pop,
    input  logic                  flush,
    output wb_entry_t             head,
    output logic [$clog2(DEPTH):0] count,
    output logic                  ready
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign ready   = (count < FULL) && !flush;
    assign do_push = push && ready;
    assign do_pop  = pop && (count != '0) && !flush;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/writeback_arbiter.sv
// Shares two registered writeback ports among NUM_SRC producer FIFOs with a
// round-robin selector that grants at most one pop per source per cycle.
module writeback_arbiter
    import cpu_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [VREG_W*NUM_SRC-1:0] src_vregid,
    input  logic [REG_W*NUM_SRC-1:0]  src_dest,
    input  logic [XLEN*NUM_SRC-1:0]   src_val,
    output logic [NUM_SRC-1:0]        src_ready,
    output logic                      wb0_en,
    output logic [VREG_W-1:0]         wb0_vregid,
    output logic [REG_W-1:0]          wb0_dest,
    output logic [XLEN-1:0]           wb0_val,
    output logic                      wb1_en,
    output logic [VREG_W-1:0]         wb1_vregid,
    output logic [REG_W-1:0]          wb1_dest,
    output logic [XLEN-1:0]           wb1_val,
    output logic                      busy
);
    localparam int SRC_W = $clog2(NUM_SRC);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    wb_entry_t          head  [NUM_SRC];
    logic [CNT_W-1:0]   count [NUM_SRC];
    logic [NUM_SRC-1:0] nonempty;
    logic [NUM_SRC-1:0] pop;
    logic [SRC_W-1:0]   rr_ptr;
    logic [SRC_W-1:0]   rr_next;
    logic [SRC_W-1:0]   g0_idx;
    logic [SRC_W-1:0]   g1_idx;
    logic               g0;
    logic               g1;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        wb_entry_t push_data;
        assign push_data = {src_vregid[VREG_W*i +: VREG_W],
                            src_dest[REG_W*i +: REG_W],
                            src_val[XLEN*i +: XLEN]};
        assign nonempty[i] = (count[i] != '0);

        wb_src_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (src_valid[i]),
            .push_data (push_data),
            .pop       (pop[i]),
            .flush     (flush),
            .head      (head[i]),
            .count     (count[i]),
            .ready     (src_ready[i])
        );
    end

    assign busy = |nonempty;

    // Walk the sources once starting at rr_ptr; first hit -> port 0, second -> port 1.
    always_comb begin
        logic [SRC_W-1:0] idx;
        idx    = '0;
        g0     = 1'b0;
        g1     = 1'b0;
        g0_idx = '0;
        g1_idx = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = SRC_W'((int'(rr_ptr) + k) % NUM_SRC);
            if (nonempty[idx]) begin
                if (!g0) begin
                    g0     = 1'b1;
                    g0_idx = idx;
                end else if (!g1) begin
                    g1     = 1'b1;
                    g1_idx = idx;
                end
            end
        end
    end

    always_comb begin
        pop     = '0;
        rr_next = rr_ptr;
        if (g0) pop[g0_idx] = 1'b1;
        if (g1) pop[g1_idx] = 1'b1;
        if (g1) begin
            rr_next = SRC_W'((int'(g1_idx) + 1) % NUM_SRC);
        end else if (g0) begin
            rr_next = SRC_W'((int'(g0_idx) + 1) % NUM_SRC);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr     <= '0;
            wb0_en     <= 1'b0;
            wb1_en     <= 1'b0;
            wb0_vregid <= '0;
            wb0_dest   <= '0;
            wb0_val    <= '0;
            wb1_vregid <= '0;
            wb1_dest   <= '0;
            wb1_val    <= '0;
        end else if (flush) begin
            rr_ptr <= '0;
            wb0_en <= 1'b0;
            wb1_en <= 1'b0;
        end else begin
            rr_ptr <= rr_next;
            wb0_en <= g0;
            wb1_en <= g1;
            if (g0) begin
                wb0_vregid <= head[g0_idx].vregid;
                wb0_dest   <= head[g0_idx].dest;
                wb0_val    <= head[g0_idx].val;
            end
            if (g1) begin
                wb1_vregid <= head[g1_idx].vregid;
                wb1_dest   <= head[g1_idx].dest;
                wb1_val    <= head[g1_idx].val;
            end
        end
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: a vector table for the basic grant
// patterns plus hand-written sequences for saturation, flush and async reset.
module tb_writeback_arbiter;
    logic        clk;
    logic        rst;
    logic        flush;
    logic [3:0]  src_valid;
    logic [19:0] src_vregid;
    logic [19:0] src_dest;
    logic [127:0] src_val;
    logic [3:0]  src_ready;
    logic        wb0_en;
    logic [4:0]  wb0_vregid;
    logic [4:0]  wb0_dest;
    logic [31:0] wb0_val;
    logic        wb1_en;
    logic [4:0]  wb1_vregid;
    logic [4:0]  wb1_dest;
    logic [31:0] wb1_val;
    logic        busy;

    int total = 0;
    int bad   = 0;

    writeback_arbiter #(.NUM_SRC(4), .FIFO_DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .src_valid  (src_valid),
        .src_vregid (src_vregid),
        .src_dest   (src_dest),
        .src_val    (src_val),
        .src_ready  (src_ready),
        .wb0_en     (wb0_en),
        .wb0_vregid (wb0_vregid),
        .wb0_dest   (wb0_dest),
        .wb0_val    (wb0_val),
        .wb1_en     (wb1_en),
        .wb1_vregid (wb1_vregid),
        .wb1_dest   (wb1_dest),
        .wb1_val    (wb1_val),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] valid;
        logic [4:0] base;
        logic       e0;
        logic [4:0] v0;
        logic       e1;
        logic [4:0] v1;
        logic       busy;
        logic [3:0] ready;
    } vec_t;

    vec_t tbl [12];

    int         grants [4];
    int         last   [4];
    logic [2:0] seq     [4];
    logic [2:0] exp_seq [4];
    int         maxgap;

    function automatic logic [4:0] dest_of(input logic [4:0] tag);
        return (tag == 5'd3) ? 5'd7 : (tag ^ 5'h15);
    endfunction

    function automatic logic [31:0] val_of(input logic [4:0] tag);
        return (tag == 5'd3) ? 32'hDEAD_BEEF : {16'hC0DE, 11'h0, tag};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [4:0] tag);
        src_vregid[5*i +: 5] = tag;
        src_dest[5*i +: 5]   = dest_of(tag);
        src_val[32*i +: 32]  = val_of(tag);
    endtask

    task automatic check_port0(input string name, input logic [4:0] tag);
        check({name, "_en0"}, wb0_en, 1);
        check({name, "_vreg0"}, wb0_vregid, tag);
        check({name, "_dest0"}, wb0_dest, dest_of(tag));
        check({name, "_val0"}, wb0_val, val_of(tag));
    endtask

    task automatic drive_full();
        for (int i = 0; i < 4; i++) begin
            if (src_ready[i]) begin
                set_src(i, {seq[i], 2'(i)});
                seq[i]++;
                src_valid[i] = 1'b1;
            end else begin
                src_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic record(input logic [4:0] v, input int cyc);
        int s;
        int gap;
        s = int'(v[1:0]);
        check($sformatf("full_order_src%0d", s), v[4:2], exp_seq[s]);
        exp_seq[s]++;
        grants[s]++;
        gap = cyc - last[s];
        if (gap > maxgap) maxgap = gap;
        last[s] = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{4'hF, 5'd8,  1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 4'hF};
        tbl[1]  = '{4'h0, 5'd0,  1'b1, 5'd8,  1'b1, 5'd9,  1'b1, 4'hF};
        tbl[2]  = '{4'h0, 5'd0,  1'b1, 5'd10, 1'b1, 5'd11, 1'b0, 4'hF};
        tbl[3]  = '{4'h0, 5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 4'hF};
        tbl[4]  = '{4'h1, 5'd3,  1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 4'hF};
        tbl[5]  = '{4'h0, 5'd0,  1'b1, 5'd3,  1'b0, 5'd0,  1'b0, 4'hF};
        tbl[6]  = '{4'h0, 5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 4'hF};
        tbl[7]  = '{4'h4, 5'd18, 1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 4'hF};
        tbl[8]  = '{4'h4, 5'd19, 1'b1, 5'd20, 1'b0, 5'd0,  1'b1, 4'hF};
        tbl[9]  = '{4'h4, 5'd20, 1'b1, 5'd21, 1'b0, 5'd0,  1'b1, 4'hF};
        tbl[10] = '{4'h0, 5'd0,  1'b1, 5'd22, 1'b0, 5'd0,  1'b0, 4'hF};
        tbl[11] = '{4'h0, 5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 4'hF};

        rst        = 1'b0;
        flush      = 1'b0;
        src_valid  = '0;
        src_vregid = '0;
        src_dest   = '0;
        src_val    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_en0", wb0_en, 0);
        check("rst_en1", wb1_en, 0);
        check("rst_vreg0", wb0_vregid, 0);
        check("rst_dest0", wb0_dest, 0);
        check("rst_val0", wb0_val, 0);
        check("rst_val1", wb1_val, 0);
        check("rst_ready", src_ready, 4'hF);
        check("rst_busy", busy, 0);
        #2 rst = 1'b1;

        // Vector table: simultaneous four-source burst, single push, src2 stream.
        for (int r = 0; r < 12; r++) begin
            src_valid = tbl[r].valid;
            for (int i = 0; i < 4; i++) set_src(i, 5'(tbl[r].base + 5'(i)));
            step();
            check($sformatf("row%0d_en0", r), wb0_en, tbl[r].e0);
            check($sformatf("row%0d_en1", r), wb1_en, tbl[r].e1);
            if (tbl[r].e0) check_port0($sformatf("row%0d", r), tbl[r].v0);
            if (tbl[r].e1) begin
                check($sformatf("row%0d_vreg1", r), wb1_vregid, tbl[r].v1);
                check($sformatf("row%0d_val1", r), wb1_val, val_of(tbl[r].v1));
            end
            check($sformatf("row%0d_busy", r), busy, tbl[r].busy);
            check($sformatf("row%0d_ready", r), src_ready, tbl[r].ready);
        end

        // All four sources kept saturated for eight grant cycles.
        for (int i = 0; i < 4; i++) begin
            grants[i]  = 0;
            last[i]    = -1;
            seq[i]     = '0;
            exp_seq[i] = '0;
        end
        maxgap = 0;
        drive_full();
        step();
        for (int cyc = 0; cyc < 8; cyc++) begin
            drive_full();
            step();
            check("full_en0", wb0_en, 1);
            check("full_en1", wb1_en, 1);
            check("full_dest0", wb0_dest, dest_of(wb0_vregid));
            record(wb0_vregid, cyc);
            record(wb1_vregid, cyc);
        end
        for (int i = 0; i < 4; i++) check($sformatf("full_grants_src%0d", i), grants[i], 4);
        check("full_maxgap_le2", (maxgap <= 2) ? 1 : 0, 1);
        src_valid = '0;
        for (int n = 0; n < 10 && busy; n++) step();
        check("drain_busy", busy, 0);

        // Flush with five entries queued and a same-cycle push.
        src_valid = 4'hF;
        for (int i = 0; i < 4; i++) set_src(i, 5'(16 + i));
        step();
        check("preflush_a_busy", busy, 1);
        src_valid = 4'h7;
        for (int i = 0; i < 3; i++) set_src(i, 5'(24 + i));
        step();
        check("preflush_b_en0", wb0_en, 1);
        check("preflush_b_en1", wb1_en, 1);
        flush     = 1'b1;
        src_valid = 4'h8;
        set_src(3, 5'd31);
        #1;
        check("flush_ready", src_ready, 4'h0);
        step();
        check("flush_en0", wb0_en, 0);
        check("flush_en1", wb1_en, 0);
        check("flush_busy", busy, 0);
        flush     = 1'b0;
        src_valid = '0;
        #1;
        check("postflush_ready", src_ready, 4'hF);
        src_valid = 4'h8;
        set_src(3, 5'd13);
        step();
        check("postflush_push_en0", wb0_en, 0);
        src_valid = '0;
        step();
        check_port0("postflush", 5'd13);
        check("postflush_en1", wb1_en, 0);
        step();
        check("postflush_idle_en0", wb0_en, 0);
        check("postflush_idle_busy", busy, 0);

        // Asynchronous reset between edges while the ports are active.
        src_valid = 4'h3;
        set_src(0, 5'd4);
        set_src(1, 5'd5);
        step();
        set_src(0, 5'd6);
        set_src(1, 5'd7);
        step();
        check_port0("prereset", 5'd4);
        check("prereset_en1", wb1_en, 1);
        check("prereset_vreg1", wb1_vregid, 5'd5);
        src_valid = '0;
        #2 rst = 1'b0;
        #1;
        check("arst_en0", wb0_en, 0);
        check("arst_en1", wb1_en, 0);
        check("arst_vreg0", wb0_vregid, 0);
        check("arst_val1", wb1_val, 0);
        check("arst_busy", busy, 0);
        check("arst_ready", src_ready, 4'hF);
        src_valid = 4'h4;
        set_src(2, 5'd7);
        step();
        check("arst_held_busy", busy, 0);
        #2 rst = 1'b1;
        step();
        check("release_busy", busy, 1);
        check("release_en0", wb0_en, 0);
        src_valid = '0;
        step();
        check_port0("release", 5'd7);
        check("release_en1", wb1_en, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
